// File: rtl/cb_config_loader.sv
// rtl/cb_config_loader.sv - connection-block configuration word loader
//
// Assembles a CFG_W-bit routing configuration from WORD-wide chunks received
// over a valid/ready stream into a shadow register, and copies it to the live
// output c only after a correctly framed load. A badly framed load parks the
// loader in an error state and leaves c untouched.
//
// Ports:
//   clk        configuration clock, all state on posedge
//   rst        asynchronous active-high reset
//   cfg_start  begin a load (honoured in idle or error state only)
//   cfg_valid  cfg_data / cfg_last valid this cycle
//   cfg_ready  loader accepts a chunk this cycle (high throughout LOAD)
//   cfg_data   chunk k lands at bits [k*WORD +: WORD]
//   cfg_last   marks the final chunk of the load
//   c          live configuration word
//   cfg_busy   load or commit in progress
//   cfg_done   one-cycle pulse while c is being updated
//   cfg_err    framing error, held until the next cfg_start or rst
module cb_config_loader #(
  parameter int CFG_W = 44,
  parameter int WORD  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WORD-1:0]  cfg_data,
  input  logic             cfg_last,
  output logic [CFG_W-1:0] c,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int NWORDS = (CFG_W + WORD - 1) / WORD;
  localparam int CNT_W  = $clog2(NWORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_ERR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CFG_W-1:0]   shadow;
  logic               xfer;
  logic               begin_load;

  assign xfer       = cfg_valid & cfg_ready;
  assign begin_load = cfg_start & ((state == S_IDLE) | (state == S_ERR));

  // Next-state logic. Framing is judged on each accepted chunk: the load is
  // good only when cfg_last arrives together with exactly the NWORDS-th chunk.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_ERR: begin
        if (cfg_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (xfer) begin
          if (cnt == LAST_IDX)  state_nxt = cfg_last ? S_COMMIT : S_ERR;
          else if (cfg_last)    state_nxt = S_ERR;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered status outputs, all derived from the
  // next state so they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= (state_nxt == S_LOAD);
      cfg_busy  <= (state_nxt == S_LOAD) | (state_nxt == S_COMMIT);
      cfg_done  <= (state_nxt == S_COMMIT);
      cfg_err   <= (state_nxt == S_ERR);
    end
  end

  // Shadow assembly. Only bits below CFG_W exist, so the part of the final
  // chunk that overhangs the word is simply never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (begin_load) begin
      cnt    <= '0;
      shadow <= '0;
    end else if ((state == S_LOAD) && xfer) begin
      for (int i = 0; i < CFG_W; i++) begin
        if ((i / WORD) == int'(cnt)) shadow[i] <= cfg_data[i % WORD];
      end
      cnt <= cnt + 1'b1;
    end
  end

  // Live word changes only on the edge leaving COMMIT (or on reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
    end else if (state == S_COMMIT) begin
      c <= shadow;
    end
  end

endmodule

// File: tb/tb_cb_config_loader.sv
// tb/tb_cb_config_loader.sv - self-checking bench for cb_config_loader
`timescale 1ns/1ps
module tb_cb_config_loader;

  localparam int CFG_W  = 44;
  localparam int WORD   = 8;
  localparam int NWORDS = 6;

  logic             clk;
  logic             rst;
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WORD-1:0]  cfg_data;
  logic             cfg_last;
  logic [CFG_W-1:0] c;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_err;

  cb_config_loader #(.CFG_W(CFG_W), .WORD(WORD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .c         (c),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs, maintained by the stimulus tasks from transaction-level rules.
  logic             exp_ready, exp_busy, exp_done, exp_err;
  logic [CFG_W-1:0] exp_c;
  bit               cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cfg_ready", 64'(cfg_ready), 64'(exp_ready));
      check("cfg_busy",  64'(cfg_busy),  64'(exp_busy));
      check("cfg_done",  64'(cfg_done),  64'(exp_done));
      check("cfg_err",   64'(cfg_err),   64'(exp_err));
      check("c",         64'(c),         64'(exp_c));
    end
  end

  // Reference: chunk k occupies bits [8k+7:8k]; anything past bit 43 is lost.
  function automatic logic [CFG_W-1:0] assemble(input logic [7:0] ch[$]);
    logic [NWORDS*WORD-1:0] t;
    t = '0;
    foreach (ch[k]) if (k < NWORDS) t[k*WORD +: WORD] = ch[k];
    return t[CFG_W-1:0];
  endfunction

  task automatic set_reset_exp();
    exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_c = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'($urandom);
      cfg_data  = 8'($urandom);
      cfg_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Drives one load. Called at #1 after a posedge. The final chunk carries
  // cfg_last=lastf; abort_after>=0 asserts rst after that many handshakes.
  task automatic run_load(input logic [7:0] ch[$], input bit lastf, input bit rnd_valid,
                          input int abort_after);
    int n;
    int k;
    int guard;
    n = ch.size();
    k = 0;
    guard = 0;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    exp_ready = 1'b1; exp_busy = 1'b1; exp_err = 1'b0; exp_done = 1'b0;
    while (k < n) begin
      if (abort_after >= 0 && k == abort_after) begin
        cfg_valid = 1'b0;
        rst = 1'b1;
        set_reset_exp();
        #1;
        check("async_c",     64'(c),         64'd0);
        check("async_ready", 64'(cfg_ready), 64'd0);
        check("async_busy",  64'(cfg_busy),  64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      cfg_valid = rnd_valid ? 1'($urandom) : 1'b1;
      cfg_data  = ch[k];
      cfg_last  = (k == n - 1) ? lastf : 1'b0;
      cfg_start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      if (cfg_valid) k++;
      guard++;
      if (guard > 300) begin
        check("load_timeout", 64'd1, 64'd0);
        break;
      end
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    cfg_last  = 1'b0;
    if (n == NWORDS && lastf) begin
      exp_ready = 1'b0; exp_done = 1'b1; exp_busy = 1'b1;
      @(posedge clk); #1;
      exp_done = 1'b0; exp_busy = 1'b0;
      exp_c = assemble(ch);
    end else begin
      exp_ready = 1'b0; exp_busy = 1'b0; exp_err = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] qff[$];
    logic [7:0] qr[$];
    int n;
    bit lf;

    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    set_reset_exp();
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: idle after reset
    idle_cycles(5);

    // 2: well-formed load
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA6};
    check("model_pin", 64'(assemble(q)), 64'h0000_0655_4433_2211);
    run_load(q, 1'b1, 1'b0, -1);
    check("lit_c", 64'(c), 64'h0000_0655_4433_2211);
    idle_cycles(2);

    // 3: same load with random valid stalls
    run_load(q, 1'b1, 1'b1, -1);
    idle_cycles(2);

    // 4: early last on third chunk, then a restart clears cfg_err
    run_load('{8'h01, 8'h02, 8'h03}, 1'b1, 1'b0, -1);
    idle_cycles(3);
    check("lit_err_c", 64'(c), 64'h0000_0655_4433_2211);
    run_load(q, 1'b1, 1'b0, -1);

    // 5: six chunks, last never set
    run_load('{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34}, 1'b0, 1'b1, -1);
    idle_cycles(2);

    // 6: reset mid-load after a good load, then all-ones load
    run_load(q, 1'b1, 1'b0, -1);
    run_load(q, 1'b1, 1'b0, 3);
    idle_cycles(2);
    qff = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(qff, 1'b1, 1'b0, -1);
    check("lit_ff", 64'(c), 64'h0000_0FFF_FFFF_FFFF);
    idle_cycles(1);

    // Random loads: random lengths, framing and stalls
    for (int t = 0; t < 40; t++) begin
      n  = $urandom_range(1, NWORDS);
      lf = (n < NWORDS) ? 1'b1 : 1'($urandom);
      qr.delete();
      for (int i = 0; i < n; i++) qr.push_back(8'($urandom));
      run_load(qr, lf, 1'($urandom), -1);
      idle_cycles($urandom_range(0, 3));
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
